// File: rtl/faxi_burst_gen.sv
// faxi_burst_gen: AXI4 slave-side burst address generator.
// Takes one AW/AR command per handshake and emits one beat descriptor per data
// beat. Commands are checked for AXI4 legality when they are accepted.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_cmd_*/o_cmd_ready    command channel (addr, len, size, burst)
//   o_beat_*/i_beat_ready  beat descriptor channel (addr, strb, idx, last)
//   o_cmd_err              one-cycle pulse after an illegal command is consumed
module faxi_burst_gen #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [7:0]      i_cmd_len,
  input  logic [2:0]      i_cmd_size,
  input  logic [1:0]      i_cmd_burst,
  output logic            o_beat_valid,
  input  logic            i_beat_ready,
  output logic [AW-1:0]   o_beat_addr,
  output logic [DW/8-1:0] o_beat_strb,
  output logic [7:0]      o_beat_idx,
  output logic            o_beat_last,
  output logic            o_cmd_err
);

  localparam int NB  = DW / 8;
  localparam int LNB = $clog2(NB);
  // Wide enough for the last-byte sum even with a 256-beat, 128-byte-beat burst.
  localparam int XW  = (AW + 1 > 17) ? AW + 1 : 17;
  localparam logic [AW-1:0] LANE_MASK = AW'(NB - 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

  state_e         state_q;
  logic [7:0]     len_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic           ready_q;
  logic           valid_q;
  logic [AW-1:0]  addr_q;
  logic [NB-1:0]  strb_q;
  logic [7:0]     idx_q;
  logic           last_q;
  logic           err_q;

  logic           cmd_err_d;
  logic [NB-1:0]  beat0_strb_d;
  logic [AW-1:0]  nxt_addr_d;
  logic [NB-1:0]  nxt_strb_d;
  logic [XW-1:0]  start_x;
  logic [XW-1:0]  last_x;
  logic [AW-1:0]  inc_s;
  logic [AW-1:0]  wrap_mask_s;

  // Lanes lo..hi: lo from the raw address, hi from the end of the aligned beat.
  function automatic logic [NB-1:0] strb_f(input logic [AW-1:0] addr,
                                          input logic [2:0]    size);
    logic [NB-1:0] s;
    logic [AW-1:0] aligned;
    int            lo;
    int            hi;
    aligned = (addr >> size) << size;
    lo      = int'(addr & LANE_MASK);
    hi      = int'((aligned + (AW'(1) << size) - AW'(1)) & LANE_MASK);
    for (int i = 0; i < NB; i++) begin
      s[i] = (i >= lo) && (i <= hi);
    end
    return s;
  endfunction

  // Command legality and beat-0 strobe, evaluated on the incoming command.
  always_comb begin
    start_x   = XW'(i_cmd_addr) & ~((XW'(1) << i_cmd_size) - XW'(1));
    last_x    = start_x + ((XW'(i_cmd_len) + XW'(1)) << i_cmd_size) - XW'(1);
    cmd_err_d = 1'b0;
    if (int'(i_cmd_size) > LNB) begin
      cmd_err_d = 1'b1;
    end else begin
      cmd_err_d = 1'b0;
    end
    case (i_cmd_burst)
      BURST_FIXED: begin
      end
      BURST_INCR: begin
        if ((last_x >> 12) != (XW'(i_cmd_addr) >> 12)) begin
          cmd_err_d = 1'b1;
        end else begin
          cmd_err_d = cmd_err_d;
        end
      end
      BURST_WRAP: begin
        if (!((i_cmd_len == 8'd1) || (i_cmd_len == 8'd3) ||
              (i_cmd_len == 8'd7) || (i_cmd_len == 8'd15))) begin
          cmd_err_d = 1'b1;
        end else if ((i_cmd_addr & ((AW'(1) << i_cmd_size) - AW'(1))) != '0) begin
          cmd_err_d = 1'b1;
        end else begin
          cmd_err_d = cmd_err_d;
        end
      end
      default: cmd_err_d = 1'b1;
    endcase
    beat0_strb_d = strb_f(i_cmd_addr, i_cmd_size);
  end

  // Next beat address and strobe from the latched command.
  always_comb begin
    inc_s       = AW'(1) << size_q;
    wrap_mask_s = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    case (burst_q)
      BURST_FIXED: nxt_addr_d = addr_q;
      BURST_INCR:  nxt_addr_d = ((addr_q >> size_q) << size_q) + inc_s;
      BURST_WRAP:  nxt_addr_d = (addr_q & ~wrap_mask_s) | ((addr_q + inc_s) & wrap_mask_s);
      default:     nxt_addr_d = addr_q;
    endcase
    if (burst_q == BURST_FIXED) begin
      nxt_strb_d = strb_q;
    end else begin
      nxt_strb_d = strb_f(nxt_addr_d, size_q);
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      idx_q   <= 8'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            if (cmd_err_d) begin
              // Illegal command is consumed; stay idle and ready.
              err_q <= 1'b1;
            end else begin
              len_q   <= i_cmd_len;
              size_q  <= i_cmd_size;
              burst_q <= i_cmd_burst;
              addr_q  <= i_cmd_addr;
              strb_q  <= beat0_strb_d;
              idx_q   <= 8'd0;
              last_q  <= (i_cmd_len == 8'd0);
              valid_q <= 1'b1;
              ready_q <= 1'b0;
              state_q <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (i_beat_ready) begin
            if (last_q) begin
              // Ready rises with valid falling: this gives the bubble cycle.
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              addr_q <= nxt_addr_d;
              strb_q <= nxt_strb_d;
              idx_q  <= idx_q + 8'd1;
              last_q <= ((idx_q + 8'd1) == len_q);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_cmd_ready  = ready_q;
  assign o_beat_valid = valid_q;
  assign o_beat_addr  = addr_q;
  assign o_beat_strb  = strb_q;
  assign o_beat_idx   = idx_q;
  assign o_beat_last  = last_q;
  assign o_cmd_err    = err_q;

endmodule

// File: tb/tb_faxi_burst_gen.sv
// Directed testbench for faxi_burst_gen (AW=32, DW=32). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_faxi_burst_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        cmd_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  faxi_burst_gen #(.AW(32), .DW(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_size(cmd_size),
    .i_cmd_burst(cmd_burst),
    .o_beat_valid(beat_valid), .i_beat_ready(beat_ready),
    .o_beat_addr(beat_addr), .o_beat_strb(beat_strb), .o_beat_idx(beat_idx),
    .o_beat_last(beat_last), .o_cmd_err(cmd_err)
  );

  // Present one command for one cycle; called at a falling edge while idle.
  task automatic send_cmd(input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a beat, capture it, and consume it with a one-cycle ready.
  task automatic take_beat(output logic [31:0] a, output logic [3:0] s,
                           output logic [7:0] x, output logic l, output logic ok);
    int n = 0;
    while (!beat_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = beat_valid;
    a = beat_addr; s = beat_strb; x = beat_idx; l = beat_last;
    beat_ready = 1'b1;
    @(negedge clk);
    beat_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, cmd_err}
        !== {1'b1, 1'b0, 32'd0, 4'd0, 8'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b addr=%h strb=%b idx=%0d last=%b err=%b expected rdy=1 rest 0",
               cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, cmd_err);
    end
  endtask

  task automatic test_incr_unaligned();
    logic [31:0] ea [4] = '{32'h1003, 32'h1004, 32'h1008, 32'h100C};
    logic [3:0]  es [4] = '{4'b1000, 4'b1111, 4'b1111, 4'b1111};
    logic [31:0] a; logic [3:0] s; logic [7:0] x; logic l; logic ok;
    send_cmd(32'h1003, 8'd3, 3'd2, 2'b01);
    n_vec++;
    if ({beat_valid, cmd_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL incr_latency: got vld/rdy=%b expected 10", {beat_valid, cmd_ready});
    end
    for (int b = 0; b < 4; b++) begin
      take_beat(a, s, x, l, ok);
      n_vec++;
      if ({ok, a, s, x, l} !== {1'b1, ea[b], es[b], 8'(b), (b == 3)}) begin
        n_err++;
        $display("FAIL incr_beat%0d: got ok=%b addr=%h strb=%b idx=%0d last=%b expected addr=%h strb=%b idx=%0d last=%b",
                 b, ok, a, s, x, l, ea[b], es[b], b, (b == 3));
      end
    end
    n_vec++;
    if ({beat_valid, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL incr_bubble: got vld/rdy=%b expected 01", {beat_valid, cmd_ready});
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [8] = '{32'h7C, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70, 32'h74, 32'h78};
    logic [31:0] a; logic [3:0] s; logic [7:0] x; logic l; logic ok;
    send_cmd(32'h7C, 8'd7, 3'd2, 2'b10);
    for (int b = 0; b < 8; b++) begin
      take_beat(a, s, x, l, ok);
      n_vec++;
      if ({ok, a, s, x, l} !== {1'b1, ea[b], 4'b1111, 8'(b), (b == 7)}) begin
        n_err++;
        $display("FAIL wrap_beat%0d: got ok=%b addr=%h strb=%b idx=%0d last=%b expected addr=%h strb=1111 idx=%0d last=%b",
                 b, ok, a, s, x, l, ea[b], b, (b == 7));
      end
    end
  endtask

  task automatic test_narrow();
    logic [31:0] ea [4] = '{32'h2, 32'h3, 32'h4, 32'h5};
    logic [3:0]  es [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [31:0] a; logic [3:0] s; logic [7:0] x; logic l; logic ok;
    send_cmd(32'h2, 8'd3, 3'd0, 2'b01);
    for (int b = 0; b < 4; b++) begin
      take_beat(a, s, x, l, ok);
      n_vec++;
      if ({ok, a, s, x, l} !== {1'b1, ea[b], es[b], 8'(b), (b == 3)}) begin
        n_err++;
        $display("FAIL narrow_beat%0d: got ok=%b addr=%h strb=%b idx=%0d last=%b expected addr=%h strb=%b idx=%0d last=%b",
                 b, ok, a, s, x, l, ea[b], es[b], b, (b == 3));
      end
    end
  endtask

  task automatic test_fixed();
    logic [31:0] a; logic [3:0] s; logic [7:0] x; logic l; logic ok;
    send_cmd(32'h40, 8'd2, 3'd2, 2'b00);
    for (int b = 0; b < 3; b++) begin
      take_beat(a, s, x, l, ok);
      n_vec++;
      if ({ok, a, s, x, l} !== {1'b1, 32'h40, 4'b1111, 8'(b), (b == 2)}) begin
        n_err++;
        $display("FAIL fixed_beat%0d: got ok=%b addr=%h strb=%b idx=%0d last=%b expected addr=00000040 strb=1111 idx=%0d last=%b",
                 b, ok, a, s, x, l, b, (b == 2));
      end
    end
  endtask

  task automatic test_errors();
    // 4KB crossing, size too big, WRAP len 5, WRAP misaligned, reserved burst.
    logic [31:0] ta [5] = '{32'hFF0, 32'h0, 32'h0, 32'h2, 32'h0};
    logic [7:0]  tl [5] = '{8'd7, 8'd0, 8'd5, 8'd3, 8'd0};
    logic [2:0]  ts [5] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd2};
    logic [1:0]  tb [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [31:0] a; logic [3:0] s; logic [7:0] x; logic l; logic ok;
    for (int t = 0; t < 5; t++) begin
      send_cmd(ta[t], tl[t], ts[t], tb[t]);
      n_vec++;
      if ({cmd_err, beat_valid, cmd_ready} !== 3'b101) begin
        n_err++;
        $display("FAIL err%0d_pulse: got err/vld/rdy=%b expected 101", t, {cmd_err, beat_valid, cmd_ready});
      end
      @(negedge clk);
      n_vec++;
      if ({cmd_err, beat_valid, cmd_ready} !== 3'b001) begin
        n_err++;
        $display("FAIL err%0d_after: got err/vld/rdy=%b expected 001", t, {cmd_err, beat_valid, cmd_ready});
      end
    end
    // Ends exactly at the 4KB boundary: legal.
    send_cmd(32'hFF0, 8'd3, 3'd2, 2'b01);
    n_vec++;
    if ({cmd_err, beat_valid} !== 2'b01) begin
      n_err++;
      $display("FAIL edge4k_accept: got err/vld=%b expected 01", {cmd_err, beat_valid});
    end
    for (int b = 0; b < 4; b++) begin
      take_beat(a, s, x, l, ok);
      n_vec++;
      if ({ok, a, x, l} !== {1'b1, 32'hFF0 + 32'(4 * b), 8'(b), (b == 3)}) begin
        n_err++;
        $display("FAIL edge4k_beat%0d: got ok=%b addr=%h idx=%0d last=%b expected addr=%h",
                 b, ok, a, x, l, 32'hFF0 + 32'(4 * b));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a; logic [3:0] s; logic [7:0] x; logic l; logic ok;
    send_cmd(32'h0, 8'd255, 3'd2, 2'b01);
    for (int b = 0; b < 256; b++) begin
      int stalls = $urandom_range(0, 2);
      for (int k = 0; k <= stalls; k++) begin
        beat_ready = (k == stalls);
        n_vec++;
        if ({beat_valid, cmd_ready, beat_addr, beat_strb, beat_idx, beat_last}
            !== {1'b1, 1'b0, 32'(4 * b), 4'b1111, 8'(b), (b == 255)}) begin
          n_err++;
          $display("FAIL bp_beat%0d_cyc%0d: got vld=%b rdy=%b addr=%h strb=%b idx=%0d last=%b expected addr=%h idx=%0d",
                   b, k, beat_valid, cmd_ready, beat_addr, beat_strb, beat_idx, beat_last, 32'(4 * b), b);
        end
        @(negedge clk);
      end
      beat_ready = 1'b0;
    end
    n_vec++;
    if ({beat_valid, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_bubble: got vld/rdy=%b expected 01", {beat_valid, cmd_ready});
    end
    // Back-to-back: next command taken in the bubble cycle.
    send_cmd(32'h20, 8'd0, 3'd2, 2'b01);
    take_beat(a, s, x, l, ok);
    n_vec++;
    if ({ok, a, s, x, l} !== {1'b1, 32'h20, 4'b1111, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_single: got ok=%b addr=%h strb=%b idx=%0d last=%b expected addr=00000020 strb=1111 idx=0 last=1",
               ok, a, s, x, l);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a; logic [3:0] s; logic [7:0] x; logic l; logic ok;
    send_cmd(32'h100, 8'd7, 3'd2, 2'b01);
    take_beat(a, s, x, l, ok);
    take_beat(a, s, x, l, ok);
    n_vec++;
    if ({beat_valid, beat_addr, beat_idx} !== {1'b1, 32'h108, 8'd2}) begin
      n_err++;
      $display("FAIL rst_pre: got vld=%b addr=%h idx=%0d expected vld=1 addr=00000108 idx=2",
               beat_valid, beat_addr, beat_idx);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, cmd_err}
        !== {1'b1, 1'b0, 32'd0, 4'd0, 8'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_async: got rdy=%b vld=%b addr=%h strb=%b idx=%0d last=%b err=%b expected rdy=1 rest 0",
               cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, cmd_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if ({beat_valid, cmd_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL rst_release%0d: got vld/rdy=%b expected 01", c, {beat_valid, cmd_ready});
      end
    end
    send_cmd(32'h44, 8'd0, 3'd2, 2'b01);
    take_beat(a, s, x, l, ok);
    n_vec++;
    if ({ok, a, s, x, l} !== {1'b1, 32'h44, 4'b1111, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_recover: got ok=%b addr=%h strb=%b idx=%0d last=%b expected addr=00000044 strb=1111 idx=0 last=1",
               ok, a, s, x, l);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
    cmd_size = 3'd0; cmd_burst = 2'd0; beat_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_incr_unaligned();
    test_wrap();
    test_narrow();
    test_fixed();
    test_errors();
    test_backpressure();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/faxi_burst_gen.md
Name: faxi_burst_gen

Overview:
Sequential AXI4 burst address generator for the slave side. It accepts one AW/AR command per handshake and emits one beat descriptor per data beat: address, byte-lane strobe, beat index and last flag. It supports FIXED, INCR and WRAP bursts, narrow and unaligned transfers, and 256-beat bursts. It sits between the slave's address-channel skid buffer and its read/write data paths, and checks commands for AXI4 protocol legality.

Parameters:
AW, 32, address width in bits (>=13)
DW, 32, data bus width in bits (8..1024, power of 2); NB = DW/8 byte lanes

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command valid
o_cmd_ready  output  1  command ready
i_cmd_addr  input  AW  start address (AxADDR)
i_cmd_len  input  8  beats-1 (AxLEN)
i_cmd_size  input  3  log2 bytes per beat (AxSIZE)
i_cmd_burst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
o_beat_valid  output  1  beat descriptor valid
i_beat_ready  input  1  beat consumed
o_beat_addr  output  AW  address of current beat
o_beat_strb  output  NB  active byte lanes of current beat
o_beat_idx  output  8  beat number, 0-based
o_beat_last  output  1  current beat is the final beat
o_cmd_err  output  1  one-cycle pulse: accepted command was illegal

Behaviour:
- Reset, async assert / sync release: state IDLE, o_cmd_ready=1, o_beat_valid=0, o_beat_addr=0, o_beat_strb=0, o_beat_idx=0, o_beat_last=0, o_cmd_err=0.
- FSM states IDLE and BURST.
  - IDLE: o_cmd_ready=1. A command handshake with a legal command latches the command, loads beat 0, and moves to BURST; o_beat_valid rises the next cycle (1-cycle latency).
  - BURST: o_cmd_ready=0, o_beat_valid=1. Outputs hold stable while i_beat_ready=0.
  - Handshake on a non-last beat: load the next beat descriptor the following cycle.
  - Handshake with o_beat_last=1: return to IDLE, o_beat_valid=0 next cycle. One bubble cycle between bursts is required.
- Illegal command, checked at acceptance:
  - burst=11
  - size > log2(NB)
  - WRAP with len not in {1,3,7,15}
  - WRAP with start address not aligned to 1<<size
  - INCR where first and last byte differ in addr[AW-1:12] (4KB crossing). Last byte = aligned_start + ((len+1)<<size) - 1, computed at AW+1 bits.
  - Response: command is consumed, o_cmd_err=1 the next cycle, no beats are issued, FSM stays IDLE.
- Beat 0 address = i_cmd_addr unmodified (unaligned allowed for INCR/FIXED).
- Next address:
  - FIXED: unchanged.
  - INCR: (addr with low size bits cleared) + (1<<size).
  - WRAP: boundary mask M = ((len+1)<<size)-1; next = (addr & ~M) | ((addr + (1<<size)) & M).
- Strobe:
  - lo = addr mod NB; hi = (aligned(addr) + (1<<size) - 1) mod NB.
  - Lanes lo..hi are set, so an unaligned first beat drops its leading lanes.
  - FIXED repeats the beat-0 strobe on every beat.
- o_beat_idx counts 0..len; o_beat_last = (idx == latched len). len=0 gives a single beat with last=1.
- Address arithmetic wraps modulo 2^AW. It cannot overflow in INCR because of the 4KB check.
- i_cmd_valid in BURST is ignored (ready=0). Commands are never dropped or double-accepted.
- Reset asserted mid-burst aborts immediately to reset values. No residual beat appears after release.

Test Plan:
- DW=32, INCR addr=0x1003 size=2 len=3 -> addrs 0x1003,0x1004,0x1008,0x100C; strb 1000,1111,1111,1111; idx 0..3; last on 4th beat only.
- WRAP addr=0x7C size=2 len=7 -> addrs 0x7C,0x60,0x64,0x68,0x6C,0x70,0x74,0x78; all strb 1111; last at 0x78.
- Narrow INCR addr=0x2 size=0 len=3 -> 0x2/0100, 0x3/1000, 0x4/0001, 0x5/0010.
- Errors:
  - FIXED addr=0x40 size=2 len=2 -> three beats at 0x40, strb 1111.
  - INCR addr=0xFF0 size=2 len=7 -> o_cmd_err pulse, zero beats, ready stays 1.
  - size=3 with DW=32 -> o_cmd_err.
  - WRAP len=5 -> o_cmd_err.
- Random i_beat_ready backpressure on a 256-beat INCR size=2 from 0x0 -> outputs stable while stalled; final addr 0x3FC, idx 255, last=1; next command accepted only after the IDLE bubble.
- Assert i_rst_n=0 at beat 2 of a len=7 burst -> all outputs zero the same cycle; after release, ready=1 and no beats until a new command.
